// File: rtl/temp_range_ctrl_if.sv
// Measurement-side bundle between a temperature consumer and temp_range_ctrl.
// master drives enable/sample/ack; slave (the controller) returns range, fan drive and status.
interface temp_range_ctrl_if;
  logic       en_m1;
  logic [4:0] temperatura;
  logic       lect;
  logic [1:0] rango;
  logic       pwm;
  logic       dato_listo;
  logic       overrun;
  logic       busy;

  modport master (
    output en_m1, temperatura, lect,
    input  rango, pwm, dato_listo, overrun, busy
  );

  modport slave (
    input  en_m1, temperatura, lect,
    output rango, pwm, dato_listo, overrun, busy
  );
endinterface

// File: rtl/temp_range_ctrl.sv
// Averages four temperature samples, classifies the mean into four ranges and drives a fan PWM.
// Optional downward hysteresis when TEMP_RANGE_HYST_EN is defined.
module temp_range_ctrl #(
  parameter int unsigned SAMPLE_DIV = 8,
  parameter logic [4:0]  T1         = 5'd15,
  parameter logic [4:0]  T2         = 5'd23,
  parameter logic [4:0]  T3         = 5'd27
) (
  input logic              clk,
  input logic              rst,
  temp_range_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StUpdate} state_e;

  localparam logic [7:0] DivLast = 8'(SAMPLE_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [6:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] rango_q, rango_d;
  logic       dato_listo_q, dato_listo_d;
  logic       overrun_q, overrun_d;
  logic [3:0] pwm_cnt_q;

  logic [4:0] avg;
  logic [1:0] avg_class;
  logic [1:0] rango_new;
  logic       dato_hold;
  logic [4:0] duty;

  assign avg       = acc_q[6:2];
  assign dato_hold = dato_listo_q & ~bus_io.lect;

  always_comb begin
    if (avg >= T3) begin
      avg_class = 2'd3;
    end else if (avg >= T2) begin
      avg_class = 2'd2;
    end else if (avg >= T1) begin
      avg_class = 2'd1;
    end else begin
      avg_class = 2'd0;
    end
  end

`ifdef TEMP_RANGE_HYST_EN
  logic [4:0] cur_bound;
  logic       drop_ok;

  // Falling out of range r needs avg < bound(r) - 2; compared as avg + 2 to avoid underflow.
  always_comb begin
    case (rango_q)
      2'd1:    cur_bound = T1;
      2'd2:    cur_bound = T2;
      2'd3:    cur_bound = T3;
      default: cur_bound = 5'd0;
    endcase
    drop_ok = (({1'b0, avg} + 6'd2) < {1'b0, cur_bound});
    if ((avg_class < rango_q) && !drop_ok) begin
      rango_new = rango_q;
    end else begin
      rango_new = avg_class;
    end
  end
`else
  assign rango_new = avg_class;
`endif

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rango_d      = rango_q;
    dato_listo_d = dato_hold;
    overrun_d    = overrun_q;

    unique case (state_q)
      StIdle: begin
        div_d = 8'd0;
        acc_d = 7'd0;
        cnt_d = 2'd0;
        if (bus_io.en_m1) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (div_q == DivLast) begin
          div_d   = 8'd0;
          state_d = StSample;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StSample: begin
        acc_d   = acc_q + {2'b00, bus_io.temperatura};
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? StUpdate : StWait;
      end
      StUpdate: begin
        rango_d      = rango_new;
        dato_listo_d = 1'b1;
        // A simultaneous ack consumes the old result, so only an unacked one overruns.
        if (dato_listo_q && !bus_io.lect) begin
          overrun_d = 1'b1;
        end
        acc_d   = 7'd0;
        cnt_d   = 2'd0;
        state_d = StWait;
      end
      default: state_d = StIdle;
    endcase

    // Disable aborts the measurement without touching the published result.
    if ((state_q != StIdle) && !bus_io.en_m1) begin
      state_d      = StIdle;
      div_d        = 8'd0;
      acc_d        = 7'd0;
      cnt_d        = 2'd0;
      rango_d      = rango_q;
      dato_listo_d = dato_hold;
      overrun_d    = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      div_q        <= 8'd0;
      acc_q        <= 7'd0;
      cnt_q        <= 2'd0;
      rango_q      <= 2'd0;
      dato_listo_q <= 1'b0;
      overrun_q    <= 1'b0;
      pwm_cnt_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rango_q      <= rango_d;
      dato_listo_q <= dato_listo_d;
      overrun_q    <= overrun_d;
      pwm_cnt_q    <= pwm_cnt_q + 4'd1;
    end
  end

  always_comb begin
    unique case (rango_q)
      2'd0:    duty = 5'd0;
      2'd1:    duty = 5'd6;
      2'd2:    duty = 5'd11;
      default: duty = 5'd16;
    endcase
  end

  assign bus_io.pwm        = ({1'b0, pwm_cnt_q} < duty);
  assign bus_io.rango      = rango_q;
  assign bus_io.dato_listo = dato_listo_q;
  assign bus_io.overrun    = overrun_q;
  assign bus_io.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_temp_range_ctrl.sv
// Directed self-checking bench for temp_range_ctrl with default parameters.
// Edge 1 is the first rising edge that samples en_m1 high; the first result is due at edge 38.
module tb_temp_range_ctrl;

  logic clk = 1'b0;
  logic rst;

  temp_range_ctrl_if bus ();

  temp_range_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.en_m1       = 1'b0;
    bus.lect        = 1'b0;
    bus.temperatura = 5'd0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_run++; if (bus.rango !== 2'd0) begin n_fail++; $display("FAIL reset_rango got %0d want 0", bus.rango); end
    n_run++; if (bus.pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm got %0b want 0", bus.pwm); end
    n_run++; if (bus.dato_listo !== 1'b0) begin n_fail++; $display("FAIL reset_dato got %0b want 0", bus.dato_listo); end
    n_run++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %0b want 0", bus.overrun); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
  endtask

  task automatic test_low_temp();
    int highs;
    do_reset();
    bus.temperatura = 5'd10;
    bus.en_m1       = 1'b1;
    tick(1);
    n_run++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL low_busy got %0b want 1", bus.busy); end
    tick(36);
    n_run++; if (bus.dato_listo !== 1'b0) begin n_fail++; $display("FAIL low_early_dato got %0b want 0 at edge 37", bus.dato_listo); end
    tick(1);
    n_run++; if (bus.dato_listo !== 1'b1) begin n_fail++; $display("FAIL low_dato got %0b want 1 at edge 38", bus.dato_listo); end
    n_run++; if (bus.rango !== 2'd0) begin n_fail++; $display("FAIL low_rango got %0d want 0", bus.rango); end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      highs += int'(bus.pwm);
      tick(1);
    end
    n_run++; if (highs != 0) begin n_fail++; $display("FAIL low_pwm got %0d high want 0", highs); end
  endtask

  task automatic test_range1();
    int highs;
    do_reset();
    bus.temperatura = 5'd20;
    bus.en_m1       = 1'b1;
    tick(19);
    bus.temperatura = 5'd21;
    tick(9);
    bus.temperatura = 5'd22;
    tick(10);
    n_run++; if (bus.dato_listo !== 1'b1) begin n_fail++; $display("FAIL r1_dato got %0b want 1", bus.dato_listo); end
    n_run++; if (bus.rango !== 2'd1) begin n_fail++; $display("FAIL r1_rango got %0d want 1", bus.rango); end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      highs += int'(bus.pwm);
      tick(1);
    end
    n_run++; if (highs != 6) begin n_fail++; $display("FAIL r1_pwm got %0d high want 6", highs); end
    n_run++; if (bus.dato_listo !== 1'b1) begin n_fail++; $display("FAIL r1_dato_hold got %0b want 1", bus.dato_listo); end
    bus.lect = 1'b1;
    tick(1);
    bus.lect = 1'b0;
    n_run++; if (bus.dato_listo !== 1'b0) begin n_fail++; $display("FAIL r1_ack got %0b want 0", bus.dato_listo); end
    n_run++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL r1_overrun got %0b want 0", bus.overrun); end
  endtask

  task automatic test_overrun();
    int highs;
    do_reset();
    bus.temperatura = 5'd28;
    bus.en_m1       = 1'b1;
    tick(38);
    n_run++; if (bus.rango !== 2'd3) begin n_fail++; $display("FAIL ov_rango got %0d want 3", bus.rango); end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      highs += int'(bus.pwm);
      tick(1);
    end
    n_run++; if (highs != 16) begin n_fail++; $display("FAIL ov_pwm got %0d high want 16", highs); end
    tick(20);
    n_run++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ov_early got %0b want 0 at edge 74", bus.overrun); end
    tick(1);
    n_run++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ov_set got %0b want 1 at edge 75", bus.overrun); end
    bus.lect = 1'b1;
    tick(40);
    bus.lect = 1'b0;
    n_run++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ov_sticky got %0b want 1", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.temperatura = 5'd28;
    bus.en_m1       = 1'b1;
    tick(74);
    bus.lect = 1'b1;
    tick(1);
    bus.lect = 1'b0;
    n_run++; if (bus.dato_listo !== 1'b1) begin n_fail++; $display("FAIL b2b_dato got %0b want 1", bus.dato_listo); end
    n_run++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %0b want 0", bus.overrun); end
    bus.lect = 1'b1;
    tick(1);
    bus.lect = 1'b0;
    n_run++; if (bus.dato_listo !== 1'b0) begin n_fail++; $display("FAIL b2b_ack got %0b want 0", bus.dato_listo); end
  endtask

  task automatic test_hyst();
    logic [1:0] exp_mid;
`ifdef TEMP_RANGE_HYST_EN
    exp_mid = 2'd3;
`else
    exp_mid = 2'd2;
`endif
    do_reset();
    bus.temperatura = 5'd28;
    bus.en_m1       = 1'b1;
    tick(38);
    n_run++; if (bus.rango !== 2'd3) begin n_fail++; $display("FAIL hy_start got %0d want 3", bus.rango); end
    bus.temperatura = 5'd26;
    tick(37);
    n_run++; if (bus.rango !== exp_mid) begin n_fail++; $display("FAIL hy_26 got %0d want %0d", bus.rango, exp_mid); end
    bus.temperatura = 5'd24;
    tick(37);
    n_run++; if (bus.rango !== 2'd2) begin n_fail++; $display("FAIL hy_24 got %0d want 2", bus.rango); end
  endtask

  task automatic test_en_drop();
    do_reset();
    bus.temperatura = 5'd28;
    bus.en_m1       = 1'b1;
    tick(38);
    bus.lect = 1'b1;
    tick(1);
    bus.lect = 1'b0;
    tick(20);
    bus.en_m1 = 1'b0;
    tick(1);
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %0b want 0", bus.busy); end
    n_run++; if (bus.rango !== 2'd3) begin n_fail++; $display("FAIL drop_rango got %0d want 3", bus.rango); end
    n_run++; if (bus.pwm !== 1'b1) begin n_fail++; $display("FAIL drop_pwm got %0b want 1", bus.pwm); end
    bus.temperatura = 5'd10;
    tick(3);
    bus.en_m1 = 1'b1;
    tick(37);
    n_run++; if (bus.dato_listo !== 1'b0) begin n_fail++; $display("FAIL drop_stale got %0b want 0 at edge 37", bus.dato_listo); end
    n_run++; if (bus.rango !== 2'd3) begin n_fail++; $display("FAIL drop_stale_rango got %0d want 3", bus.rango); end
    tick(1);
    n_run++; if (bus.dato_listo !== 1'b1) begin n_fail++; $display("FAIL drop_dato got %0b want 1 at edge 38", bus.dato_listo); end
    n_run++; if (bus.rango !== 2'd0) begin n_fail++; $display("FAIL drop_rango_new got %0d want 0", bus.rango); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.temperatura = 5'd28;
    bus.en_m1       = 1'b1;
    tick(40);
    #2;
    rst = 1'b0;
    #1;
    n_run++; if (bus.rango !== 2'd0) begin n_fail++; $display("FAIL ar_rango got %0d want 0", bus.rango); end
    n_run++; if (bus.pwm !== 1'b0) begin n_fail++; $display("FAIL ar_pwm got %0b want 0", bus.pwm); end
    n_run++; if (bus.dato_listo !== 1'b0) begin n_fail++; $display("FAIL ar_dato got %0b want 0", bus.dato_listo); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %0b want 0", bus.busy); end
    #1;
    rst = 1'b1;
    tick(37);
    n_run++; if (bus.dato_listo !== 1'b0) begin n_fail++; $display("FAIL ar_early got %0b want 0 at edge 37", bus.dato_listo); end
    tick(1);
    n_run++; if (bus.dato_listo !== 1'b1) begin n_fail++; $display("FAIL ar_dato_new got %0b want 1 at edge 38", bus.dato_listo); end
    n_run++; if (bus.rango !== 2'd3) begin n_fail++; $display("FAIL ar_rango_new got %0d want 3", bus.rango); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst             = 1'b0;
    bus.en_m1       = 1'b0;
    bus.lect        = 1'b0;
    bus.temperatura = 5'd0;
    test_reset();
    test_low_temp();
    test_range1();
    test_overrun();
    test_back_to_back();
    test_hyst();
    test_en_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
